// File: rtl/ltc2387_pkg.sv
// Shared types and derived timing constants for the LTC2387 conversion controller
// and two-lane serial receiver.
package ltc2387_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV_HI,
    CONV_WAIT,
    READ,
    GAP
  } state_t;

  // Sampled sck edges per word: two bits arrive on every edge.
  function automatic int sck_edges(input int adc_bits);
    return adc_bits / 2;
  endfunction

  // One extra toggle returns sck low after the final sampled edge.
  function automatic int sck_toggles(input int adc_bits);
    return sck_edges(adc_bits) + 1;
  endfunction

  function automatic int min_period(input int adc_bits, input int cnv_high,
                                    input int conv, input int delay);
    return cnv_high + conv + sck_toggles(adc_bits) + delay + 1;
  endfunction

endpackage

// File: rtl/ltc2387_deser.sv
// Two-lane MSB-first shifter. The word output already contains the lane pair
// present this cycle, so the complete sample is visible during the last capture.
module ltc2387_deser #(
  parameter int ADC_BITS = 18
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                strobe,
  input  logic                da,
  input  logic                db,
  output logic [ADC_BITS-1:0] word
);

  logic [ADC_BITS-3:0] shift_q;

  assign word = {shift_q, da, db};

  always_ff @(posedge clk) begin
    if (clear) begin
      shift_q <= '0;
    end else if (strobe) begin
      shift_q <= word[ADC_BITS-3:0];
    end
  end

endmodule

// File: rtl/ltc2387_readout.sv
// LTC2387 conversion controller: CNV pulse generation, gated sck burst, delayed
// lane capture, post-enable discard and sample strobing.
module ltc2387_readout
  import ltc2387_pkg::*;
#(
  parameter int ADC_BITS        = 18,
  parameter int CNV_HIGH_CYCLES = 2,
  parameter int CONV_CYCLES     = 16,
  parameter int CAPTURE_DELAY   = 2,
  parameter int DISCARD         = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [15:0]         period,
  output logic                cnv,
  output logic                sck,
  input  logic                da,
  input  logic                db,
  output logic                adc_valid,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                period_err,
  output logic [31:0]         sample_count,
  output logic                busy
);

  localparam int E          = sck_edges(ADC_BITS);
  localparam int T          = sck_toggles(ADC_BITS);
  localparam int R          = CNV_HIGH_CYCLES + CONV_CYCLES;
  localparam int MIN_PERIOD = min_period(ADC_BITS, CNV_HIGH_CYCLES, CONV_CYCLES, CAPTURE_DELAY);
  localparam int DW         = $clog2(DISCARD + 2);

  localparam logic [15:0]   CNV_LAST   = 16'(CNV_HIGH_CYCLES - 1);
  localparam logic [15:0]   WAIT_LAST  = 16'(R - 1);
  localparam logic [15:0]   READ_FIRST = 16'(R);
  localparam logic [15:0]   READ_LAST  = 16'(R + T + CAPTURE_DELAY);
  localparam logic [15:0]   MIN_P      = 16'(MIN_PERIOD);
  localparam logic [15:0]   T_W        = 16'(T);
  localparam logic [15:0]   E_W        = 16'(E);
  localparam logic [DW-1:0] DISCARD_W  = DW'(DISCARD);

  state_t              state, state_nxt;
  logic                en_q, en_prev, en_rise;
  logic [15:0]         pcnt, p_eff, rel;
  logic                period_done, start_cnv;
  logic                stb_src, last_src, cap_stb, cap_last;
  logic [DW-1:0]       disc_cnt;
  logic [ADC_BITS-1:0] word;

  assign en_rise     = en_q & ~en_prev;
  assign period_done = (pcnt == p_eff - 16'd1);
  assign rel         = pcnt - READ_FIRST;
  assign cnv         = (state == CNV_HI);
  assign busy        = (state != IDLE);
  assign sck         = (state == READ) && (rel < T_W) && !rel[0];
  assign stb_src     = (state == READ) && (rel < E_W);
  assign last_src    = (state == READ) && (rel == E_W - 16'd1);

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:      if (en_rise) state_nxt = CNV_HI;
      CNV_HI:    if (pcnt == CNV_LAST) state_nxt = CONV_WAIT;
      CONV_WAIT: if (pcnt == WAIT_LAST) state_nxt = READ;
      READ:      if (pcnt == READ_LAST) state_nxt = period_done ? (en_q ? CNV_HI : IDLE) : GAP;
      GAP:       if (period_done) state_nxt = en_q ? CNV_HI : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign start_cnv = (state_nxt == CNV_HI) && (state != CNV_HI);

  // pcnt is the cycle index since the last CNV rise; all phase boundaries key off it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      en_q       <= 1'b0;
      en_prev    <= 1'b0;
      pcnt       <= '0;
      p_eff      <= MIN_P;
      period_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      en_q    <= enable;
      en_prev <= en_q;
      if (start_cnv) begin
        pcnt  <= '0;
        p_eff <= (period < MIN_P) ? MIN_P : period;
        if (period < MIN_P) period_err <= 1'b1;
      end else if (state != IDLE) begin
        pcnt <= pcnt + 16'd1;
      end
    end
  end

  if (CAPTURE_DELAY == 0) begin : g_no_delay
    assign cap_stb  = stb_src;
    assign cap_last = last_src;
  end else begin : g_delay
    logic [CAPTURE_DELAY-1:0] stb_q, last_q;
    always_ff @(posedge clk) begin
      // NOTE: the delay line is reset so a reset mid-read cannot release a late capture.
      if (rst) begin
        stb_q  <= '0;
        last_q <= '0;
      end else begin
        stb_q[0]  <= stb_src;
        last_q[0] <= last_src;
        for (int i = 1; i < CAPTURE_DELAY; i++) begin
          stb_q[i]  <= stb_q[i-1];
          last_q[i] <= last_q[i-1];
        end
      end
    end
    assign cap_stb  = stb_q[CAPTURE_DELAY-1];
    assign cap_last = last_q[CAPTURE_DELAY-1];
  end

  ltc2387_deser #(
    .ADC_BITS(ADC_BITS)
  ) u_deser (
    .clk   (clk),
    .clear (rst | start_cnv),
    .strobe(cap_stb),
    .da    (da),
    .db    (db),
    .word  (word)
  );

  // The final capture decides drop or emit, so the strobe lands the cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_valid    <= 1'b0;
      adc_data     <= '0;
      disc_cnt     <= '0;
      sample_count <= '0;
    end else begin
      adc_valid <= 1'b0;
      if (state == IDLE && en_rise) begin
        disc_cnt     <= '0;
        sample_count <= '0;
      end else if (cap_last) begin
        if (disc_cnt < DISCARD_W) begin
          disc_cnt <= disc_cnt + DW'(1);
        end else begin
          adc_valid    <= 1'b1;
          adc_data     <= word;
          sample_count <= sample_count + 32'd1;
        end
      end
    end
  end

endmodule
